// File: rtl/simplerisc_pkg.sv
// simplerisc_pkg: shared SimpleRisc register-file widths and writeback request type
package simplerisc_pkg;
    localparam int REG_W    = 4;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 16;
    localparam logic [REG_W-1:0] RA_IDX = 4'd15;
    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } wb_req_t;
endpackage

// File: rtl/wb_result_fifo.sv
// wb_result_fifo: DEPTH-entry FIFO of multicycle writeback results
// Ports: i_push/i_data write the tail, i_pop drops the head (o_head);
//        o_full/o_empty/o_count report occupancy; o_vld/o_rds expose every
//        slot's valid bit and destination so the owner can build a busy mask.
module wb_result_fifo
    import simplerisc_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_push,
    input  wb_req_t                     i_data,
    input  logic                        i_pop,
    output wb_req_t                     o_head,
    output logic                        o_full,
    output logic                        o_empty,
    output logic [$clog2(DEPTH):0]      o_count,
    output logic [DEPTH-1:0]            o_vld,
    output logic [DEPTH-1:0][REG_W-1:0] o_rds
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    wb_req_t          r_mem [DEPTH];
    logic [PW-1:0]    r_wp;
    logic [PW-1:0]    r_rp;
    logic [CW-1:0]    r_cnt;
    logic [DEPTH-1:0] r_vld;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            r_vld <= '0;
        end else begin
            if (i_push) begin
                r_wp        <= r_wp + 1'b1;
                r_vld[r_wp] <= 1'b1;
            end
            if (i_pop) begin
                r_rp        <= r_rp + 1'b1;
                r_vld[r_rp] <= 1'b0;
            end
            r_cnt <= (i_push && !i_pop) ? r_cnt + 1'b1 :
                     (!i_push && i_pop) ? r_cnt - 1'b1 : r_cnt;
        end
    end
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wp] <= i_data;
    end
    assign o_head  = r_mem[r_rp];
    assign o_full  = r_cnt == CW'(DEPTH);
    assign o_empty = r_cnt == '0;
    assign o_count = r_cnt;
    assign o_vld   = r_vld;
    for (genvar g = 0; g < DEPTH; g++) begin : g_rd
        assign o_rds[g] = r_mem[g].rd;
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between writeback and a buffered multicycle unit
// Ports: p_* writeback-stage request; m_valid/m_rd/m_data/m_ready multicycle
//        result handshake; stall_pipe forces the writeback stage to hold;
//        rf_we/rf_rd/rf_data registered write port; busy_mask marks
//        destinations still buffered; err_waw sticky write-after-write flag.
module regfile_wb_arbiter
    import simplerisc_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                p_valid,
    input  logic                p_is_wb,
    input  logic [REG_W-1:0]    p_rd,
    input  logic [DATA_W-1:0]   p_data,
    input  logic                m_valid,
    input  logic [REG_W-1:0]    m_rd,
    input  logic [DATA_W-1:0]   m_data,
    output logic                m_ready,
    output logic                stall_pipe,
    output logic                rf_we,
    output logic [REG_W-1:0]    rf_rd,
    output logic [DATA_W-1:0]   rf_data,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic                err_waw
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    wb_req_t                     w_head;
    logic                        w_full;
    logic                        w_empty;
    logic [CW-1:0]               w_count;
    logic [DEPTH-1:0]            w_vld;
    logic [DEPTH-1:0][REG_W-1:0] w_rds;
    logic                        w_push;
    logic                        w_grant_pipe;
    logic                        w_pop;
    logic                        w_starve_hit;
    logic [SW-1:0]               r_starve;
    assign m_ready = !w_full;
    // A full FIFO refuses pushes even when its head pops in the same cycle.
    assign w_push = m_valid && m_ready;
    wb_result_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_data  ('{rd: m_rd, data: m_data}),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count),
        .o_vld   (w_vld),
        .o_rds   (w_rds)
    );
    // The pipeline wins unless it is being stalled; any cycle it does not
    // claim goes to the FIFO head, which covers the forced-drain stall cycle.
    assign w_grant_pipe = p_valid && p_is_wb && !stall_pipe;
    assign w_pop        = !w_empty && !w_grant_pipe;
    assign w_starve_hit = !w_empty && !w_pop && r_starve == SW'(STARVE_LIMIT - 1);
    always_comb begin
        busy_mask = '0;
        for (int i = 0; i < DEPTH; i++)
            if (w_vld[i]) busy_mask[w_rds[i]] = 1'b1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve   <= '0;
            stall_pipe <= 1'b0;
            rf_we      <= 1'b0;
            rf_rd      <= '0;
            rf_data    <= '0;
            err_waw    <= 1'b0;
        end else begin
            r_starve   <= (w_empty || w_pop || w_starve_hit) ? '0 : r_starve + 1'b1;
            stall_pipe <= w_starve_hit;
            rf_we      <= w_grant_pipe || w_pop;
            if (w_grant_pipe) begin
                rf_rd   <= p_rd;
                rf_data <= p_data;
            end else if (w_pop) begin
                rf_rd   <= w_head.rd;
                rf_data <= w_head.data;
            end
            if (w_grant_pipe && busy_mask[p_rd]) err_waw <= 1'b1;
        end
    end
    // A stall cycle always pops, so the FIFO is never empty while stalling.
    a_stall_nonempty: assert property (@(posedge clk) disable iff (!rst_n) stall_pipe |-> !w_empty);
    a_count_range: assert property (@(posedge clk) disable iff (!rst_n) w_count <= CW'(DEPTH));
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: random stimulus against a queue-based model of the write-port arbiter
module tb_regfile_wb_arbiter;
    import simplerisc_pkg::*;
    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 4;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        p_valid = 1'b0;
    logic        p_is_wb = 1'b0;
    logic [3:0]  p_rd = '0;
    logic [31:0] p_data = '0;
    logic        m_valid = 1'b0;
    logic [3:0]  m_rd = '0;
    logic [31:0] m_data = '0;
    logic        m_ready;
    logic        stall_pipe;
    logic        rf_we;
    logic [3:0]  rf_rd;
    logic [31:0] rf_data;
    logic [15:0] busy_mask;
    logic        err_waw;
    int n_vec = 0;
    int n_err = 0;
    wb_req_t     q[$];
    bit          e_stall, e_we, e_err, last_stall;
    logic [3:0]  e_rd;
    logic [31:0] e_data;
    int          starve;
    regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .p_valid(p_valid), .p_is_wb(p_is_wb), .p_rd(p_rd), .p_data(p_data),
        .m_valid(m_valid), .m_rd(m_rd), .m_data(m_data), .m_ready(m_ready),
        .stall_pipe(stall_pipe), .rf_we(rf_we), .rf_rd(rf_rd), .rf_data(rf_data),
        .busy_mask(busy_mask), .err_waw(err_waw)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    function automatic logic [3:0] pick_rd();
        return ($urandom_range(0, 3) == 0) ? RA_IDX : 4'($urandom_range(0, 3));
    endfunction
    task automatic model_clear();
        q.delete();
        e_stall = 0; e_we = 0; e_err = 0; last_stall = 0;
        e_rd = '0; e_data = '0; starve = 0;
    endtask
    // One clock: check outputs at the falling edge, drive new inputs, advance the model.
    task automatic step(input int pw, input int pm, input int nowb);
        logic [15:0] busy;
        wb_req_t     r;
        int          sz;
        bit          popped;
        @(negedge clk);
        busy = '0;
        foreach (q[i]) busy[q[i].rd] = 1'b1;
        chk("m_ready", m_ready, q.size() < DEPTH);
        chk("stall_pipe", stall_pipe, e_stall);
        chk("rf_we", rf_we, e_we);
        chk("rf_rd", rf_rd, e_rd);
        chk("rf_data", rf_data, e_data);
        chk("busy_mask", busy_mask, busy);
        chk("err_waw", err_waw, e_err);
        if (!last_stall) begin
            p_valid = $urandom_range(0, 99) < pw;
            p_is_wb = $urandom_range(0, 99) >= nowb;
            p_rd    = pick_rd();
            p_data  = $urandom;
        end
        if (!(m_valid && q.size() >= DEPTH)) begin
            m_valid = $urandom_range(0, 99) < pm;
            m_rd    = pick_rd();
            m_data  = $urandom;
        end
        sz = q.size();
        popped = 0;
        if (p_valid && p_is_wb && !e_stall) begin
            if (busy[p_rd]) e_err = 1;
            e_we = 1; e_rd = p_rd; e_data = p_data;
        end else if (sz > 0) begin
            r = q.pop_front();
            e_we = 1; e_rd = r.rd; e_data = r.data;
            popped = 1;
        end else e_we = 0;
        if (m_valid && sz < DEPTH) q.push_back('{rd: m_rd, data: m_data});
        last_stall = e_stall;
        e_stall = 0;
        if (sz > 0 && !popped) begin
            starve++;
            if (starve == STARVE_LIMIT) begin
                e_stall = 1;
                starve = 0;
            end
        end else starve = 0;
        @(posedge clk);
    endtask
    // Asynchronous reset taken mid-cycle: outputs must clear before any edge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_m_ready", m_ready, 1);
        chk("rst_stall", stall_pipe, 0);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_rf_rd", rf_rd, 0);
        chk("rst_rf_data", rf_data, 0);
        chk("rst_busy", busy_mask, 0);
        chk("rst_err", err_waw, 0);
        p_valid = 0; m_valid = 0;
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask
    initial begin
        int n;
        model_clear();
        do_reset();
        for (int i = 0; i < 300; i++) step(85, 40, 10);
        do_reset();
        for (int i = 0; i < 300; i++) step(30, 50, 10);
        do_reset();
        for (int i = 0; i < 300; i++) step(70, 60, 50);
        n = 0;
        while (!(q.size() == DEPTH && e_stall) && n < 400) begin
            step(95, 70, 0);
            n++;
        end
        chk("prefill_deep_stall", n < 400, 1);
        do_reset();
        for (int i = 0; i < 50; i++) step(50, 50, 20);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single register-file write port of the SimpleRisc core.
- Shares that port between two sources:
  - the in-order pipeline writeback stage, which supplies data/rd/is_wb already resolved for ld/call/ALU;
  - a multicycle execution unit (mul/div) whose results return out of band.
- Buffers multicycle results in a small FIFO and exports a pending-destination mask for decode interlocks.
- Forces a one-cycle pipeline stall when a buffered result has waited too long.

Parameters:
- DEPTH, 2, multicycle result FIFO entries; power of two, at least 2.
- STARVE_LIMIT, 4, consecutive cycles the FIFO head may lose arbitration before stall_pipe is raised.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- p_valid  input  1  writeback stage holds a valid instruction.
- p_is_wb  input  1  that instruction writes the register file.
- p_rd  input  4  destination register; already 15 for call.
- p_data  input  32  writeback data (ldresult, aluresult or pc+4).
- m_valid  input  1  multicycle unit presents a result.
- m_rd  input  4  destination of the multicycle result.
- m_data  input  32  multicycle result.
- m_ready  output  1  FIFO can accept; equals not-full.
- stall_pipe  output  1  pipeline must hold its writeback stage this cycle.
- rf_we  output  1  register-file write enable (registered).
- rf_rd  output  4  register-file write address (registered).
- rf_data  output  32  register-file write data (registered).
- busy_mask  output  16  bit i set while any valid FIFO entry targets ri.
- err_waw  output  1  sticky write-after-write hazard flag.

Behaviour:
- Reset (async, rst_n low):
  - rf_we=0, rf_rd=0, rf_data=0, stall_pipe=0, busy_mask=0, err_waw=0.
  - FIFO empty, so m_ready=1.
  - Starvation counter=0.
  - Reset mid-operation discards all buffered results.
- Push: m_valid & m_ready pushes {m_rd,m_data} at the clock edge. m_ready = not-full only; a pop in the same cycle does not free a slot for a push when full.
- Per-cycle arbitration, in priority order:
  - (a) stall_pipe=1 and FIFO non-empty: grant FIFO head and pop it.
  - (b) p_valid & p_is_wb & !stall_pipe: grant pipeline.
  - (c) FIFO non-empty: grant FIFO head and pop it.
  - (d) otherwise: no grant.
- Pipeline ignored cases:
  - p_valid with p_is_wb=0 is never granted; that cycle is available to the FIFO.
  - While stall_pipe=1 the pipeline presents the same instruction again next cycle; the arbiter ignores it that cycle.
- Write port: the granted source is registered onto rf_we/rf_rd/rf_data at the next edge, giving one-cycle latency. With no grant, rf_we=0 and rf_rd/rf_data hold their previous values.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and the head is not granted.
  - Clears on every pop or when the FIFO is empty.
  - When the count reaches STARVE_LIMIT, stall_pipe is asserted (registered) for exactly one cycle, and the counter clears.
  - stall_pipe never asserts with an empty FIFO.
- busy_mask: combinational OR of one-hot(rd) over valid FIFO entries. Duplicate rd entries keep the bit set until the last one pops. An entry popped this cycle still shows in busy_mask this cycle.
- err_waw: set on a pipeline grant whose p_rd has busy_mask[p_rd]=1. Sticky until reset. No data is dropped; both writes proceed in grant order.
- FIFO pointers wrap modulo DEPTH; full/empty are tracked with a count register of width clog2(DEPTH)+1.

Decomposition:
- Shared package simplerisc_pkg holds:
  - REG_W=4, DATA_W=32, NUM_REGS=16;
  - typedef wb_req_t {rd, data};
  - RA_IDX=4'd15 (call destination).
- One sub-module: wb_result_fifo, a parameterised DEPTH x wb_req_t FIFO with push/pop/full/empty/count and per-entry valid/rd visibility for busy_mask.
- Arbitration, starvation counter and output registers stay in the top module.

Test Plan:
- Pipeline only: p_valid=1, p_is_wb=1, p_rd=4, p_data=32'hAABBCCDD, FIFO empty -> next cycle rf_we=1, rf_rd=4, rf_data=32'hAABBCCDD; stall_pipe=0.
- Idle port: m_valid=1, m_rd=7, m_data=32'hCAFEBABE with no pipeline write -> push, busy_mask=16'h0080 -> next cycle popped, one cycle later rf_we=1, rf_rd=7, busy_mask=0.
- Starvation: FIFO holds {rd=3, 32'h1234}; pipeline writes r1 every cycle -> after 4 lost cycles stall_pipe=1 for one cycle; following cycle rf_rd=3, rf_data=32'h1234; pipeline write resumes after.
- Full FIFO: push 2 results while pipeline writes continuously -> m_ready=0; a third m_valid is held, no push; m_ready returns 1 the cycle after the first pop.
- WAW: FIFO holds rd=15 and pipeline call writes rd=15 -> err_waw=1 and stays 1; both writes appear on the port in grant order.
- Reset mid-op: FIFO 2 deep, stall_pipe=1, rst_n pulsed low -> all outputs at reset values immediately, m_ready=1, busy_mask=0.
